// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, the instruction bus, the redirect source and decode.
// master = fetch stage side, slave = environment side.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [31:0] ibus_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;
    logic [31:0] fetch_count;

    modport master (
        input  redirect_valid, redirect_pc,
        input  ibus_addr_ok, ibus_data_ok, ibus_rdata,
        input  out_ready,
        output ibus_req, ibus_addr,
        output out_valid, out_pc, out_instr, out_exc,
        output fetch_count
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output ibus_addr_ok, ibus_data_ok, ibus_rdata,
        output out_ready,
        input  ibus_req, ibus_addr,
        input  out_valid, out_pc, out_instr, out_exc,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one bus read per instruction and
// hands {pc, instr, exc} to decode; redirects squash any fetch still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master fu
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   count_q, count_d;
    logic              exc_q, exc_d;
    logic              pc_aligned;
    logic              req;

    assign pc_aligned = (pc_q[1:0] == 2'b00);
    assign req        = (state_q == S_REQ) && pc_aligned;

    // Next-state and datapath updates; a redirect overrides every other event.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        count_d = count_q;

        case (state_q)
            S_REQ: begin
                if (fu.redirect_valid) begin
                    pc_d    = fu.redirect_pc;
                    state_d = (req && fu.ibus_addr_ok) ? S_DROP : S_REQ;
                end else if (!pc_aligned) begin
                    instr_d = '0;
                    exc_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (fu.ibus_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fu.redirect_valid) begin
                    pc_d    = fu.redirect_pc;
                    state_d = fu.ibus_data_ok ? S_REQ : S_DROP;
                end else if (fu.ibus_data_ok) begin
                    instr_d = fu.ibus_rdata;
                    exc_d   = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fu.redirect_valid) begin
                    pc_d    = fu.redirect_pc;
                    state_d = S_REQ;
                end else if (fu.out_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    count_d = count_q + XLEN'(1);
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (fu.redirect_valid) begin
                    pc_d = fu.redirect_pc;
                end
                if (fu.ibus_data_ok) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            exc_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
            count_q <= count_d;
        end
    end

    assign fu.ibus_req    = req;
    assign fu.ibus_addr   = pc_q;
    assign fu.out_valid   = (state_q == S_HOLD);
    assign fu.out_pc      = pc_q;
    assign fu.out_instr   = instr_q;
    assign fu.out_exc     = exc_q;
    assign fu.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized bus/redirect/decode traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if fu();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .fu    (fu.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: architectural facts about the fetch stage, not its state encoding.
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_instr;
    bit          m_exc;
    bit          m_held;   // an instruction is being offered to decode
    bit          m_out;    // a bus response is owed to us
    bit          m_stale;  // that owed response belongs to a redirected-away PC

    // Bench-side bus responder.
    bit s_pend;
    int s_dly;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req();
        return !m_held && !m_out && (m_pc[1:0] == 2'b00);
    endfunction

    task automatic model_reset();
        m_pc = 32'hbfc0_0000; m_count = '0; m_instr = '0; m_exc = 1'b0;
        m_held = 1'b0; m_out = 1'b0; m_stale = 1'b0;
        s_pend = 1'b0; s_dly = 0;
    endtask

    task automatic slave_update();
        if (s_pend) begin
            if (fu.ibus_data_ok) s_pend = 1'b0;
            else if (s_dly > 0) s_dly--;
        end else if (fu.ibus_addr_ok && m_req()) begin
            s_pend = 1'b1;
            s_dly  = int'($urandom_range(0, 3));
        end
    endtask

    task automatic model_update();
        bit req;
        req = m_req();
        if (fu.redirect_valid) begin
            m_held = 1'b0;
            if (m_out) begin
                if (fu.ibus_data_ok) m_out = 1'b0;
                else                 m_stale = 1'b1;
            end else if (req && fu.ibus_addr_ok) begin
                m_out = 1'b1; m_stale = 1'b1;
            end
            m_pc = fu.redirect_pc;
        end else if (m_held) begin
            if (fu.out_ready) begin
                m_pc = m_pc + 32'd4; m_count = m_count + 32'd1; m_held = 1'b0;
            end
        end else if (m_out) begin
            if (fu.ibus_data_ok) begin
                m_out = 1'b0;
                if (!m_stale) begin
                    m_held = 1'b1; m_instr = fu.ibus_rdata; m_exc = 1'b0;
                end
                m_stale = 1'b0;
            end
        end else if (m_pc[1:0] != 2'b00) begin
            m_held = 1'b1; m_instr = '0; m_exc = 1'b1;
        end else if (fu.ibus_addr_ok) begin
            m_out = 1'b1; m_stale = 1'b0;
        end
    endtask

    task automatic model_cmp();
        chk("ibus_req",    32'(fu.ibus_req),  32'(m_req()));
        chk("ibus_addr",   fu.ibus_addr,      m_pc);
        chk("out_valid",   32'(fu.out_valid), 32'(m_held));
        chk("fetch_count", fu.fetch_count,    m_count);
        if (m_held) begin
            chk("out_pc",    fu.out_pc,          m_pc);
            chk("out_instr", fu.out_instr,       m_instr);
            chk("out_exc",   32'(fu.out_exc),    32'(m_exc));
        end
    endtask

    task automatic drive(input bit aok, input bit dok, input logic [31:0] rdata,
                         input bit rv, input logic [31:0] rpc, input bit rdy);
        fu.ibus_addr_ok   = aok;
        fu.ibus_data_ok   = dok;
        fu.ibus_rdata     = rdata;
        fu.redirect_valid = rv;
        fu.redirect_pc    = rpc;
        fu.out_ready      = rdy;
    endtask

    // One clock: model advances on the edge, outputs compared half a cycle later.
    task automatic tick();
        @(posedge clk);
        slave_update();
        model_update();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic rand_inputs(input int redirect_pct);
        bit aok, dok, rv, rdy;
        logic [31:0] r, rpc;
        aok = m_req() ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 20);
        dok = s_pend ? (s_dly == 0) : (!aok && ($urandom_range(0, 99) < 15));
        rv  = ($urandom_range(0, 99) < redirect_pct);
        rdy = ($urandom_range(0, 99) < 50);
        r   = $urandom;
        case (r[2:0])
            3'd0:    rpc = {r[31:2], 2'b10};
            3'd1:    rpc = {r[31:2], 2'b01};
            3'd2:    rpc = 32'hffff_fffc;
            default: rpc = {r[31:2], 2'b00};
        endcase
        drive(aok, dok, $urandom, rv, rpc, rdy);
    endtask

    initial begin
        bit reached;
        reset = 1'b1;
        drive(0, 0, '0, 0, '0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst ibus_req",    32'(fu.ibus_req),  32'd1);
        chk("rst ibus_addr",   fu.ibus_addr,      32'hbfc0_0000);
        chk("rst out_valid",   32'(fu.out_valid), 32'd0);
        chk("rst fetch_count", fu.fetch_count,    32'd0);

        // Best-case fetch
        drive(1, 0, '0, 0, '0, 1);              tick();
        drive(0, 1, 32'h2408_0001, 0, '0, 1);   tick();
        chk("t1 out_valid", 32'(fu.out_valid), 32'd1);
        chk("t1 out_pc",    fu.out_pc,         32'hbfc0_0000);
        chk("t1 out_instr", fu.out_instr,      32'h2408_0001);
        drive(0, 0, '0, 0, '0, 1);              tick();
        chk("t1 next addr", fu.ibus_addr,      32'hbfc0_0004);
        chk("t1 count",     fu.fetch_count,    32'd1);
        chk("t1 next req",  32'(fu.ibus_req),  32'd1);

        // Decode stalls with bus noise
        drive(1, 0, '0, 0, '0, 0);              tick();
        drive(0, 1, 32'h3c1d_8000, 0, '0, 0);   tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2 hold valid", 32'(fu.out_valid), 32'd1);
            chk("t2 hold pc",    fu.out_pc,         32'hbfc0_0004);
            chk("t2 hold instr", fu.out_instr,      32'h3c1d_8000);
            chk("t2 hold req",   32'(fu.ibus_req),  32'd0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 0, '0, 0);
            tick();
        end
        drive(0, 0, '0, 0, '0, 1);              tick();
        chk("t2 addr", fu.ibus_addr,   32'hbfc0_0008);
        chk("t2 count", fu.fetch_count, 32'd2);

        // Redirect while waiting; stale response arrives later
        drive(1, 0, '0, 0, '0, 0);              tick();
        drive(0, 0, '0, 1, 32'h8000_0180, 0);   tick();
        chk("t3 drop valid", 32'(fu.out_valid), 32'd0);
        chk("t3 drop req",   32'(fu.ibus_req),  32'd0);
        drive(0, 0, '0, 0, '0, 1);              tick();
        chk("t3 drop req2",  32'(fu.ibus_req),  32'd0);
        drive(0, 1, 32'hdead_beef, 0, '0, 1);   tick();
        chk("t3 req",   32'(fu.ibus_req),  32'd1);
        chk("t3 addr",  fu.ibus_addr,      32'h8000_0180);
        chk("t3 valid", 32'(fu.out_valid), 32'd0);
        drive(1, 0, '0, 0, '0, 0);              tick();
        drive(0, 1, 32'h2402_000a, 0, '0, 0);   tick();
        chk("t3 out_pc",    fu.out_pc,    32'h8000_0180);
        chk("t3 out_instr", fu.out_instr, 32'h2402_000a);
        drive(0, 0, '0, 0, '0, 1);              tick();
        chk("t3 count", fu.fetch_count, 32'd3);

        // Misaligned redirect target
        drive(0, 0, '0, 1, 32'h0000_0002, 0);   tick();
        chk("t4 req",   32'(fu.ibus_req),  32'd0);
        chk("t4 valid", 32'(fu.out_valid), 32'd0);
        drive(0, 0, '0, 0, '0, 0);              tick();
        chk("t4 valid1", 32'(fu.out_valid), 32'd1);
        chk("t4 exc",    32'(fu.out_exc),   32'd1);
        chk("t4 instr",  fu.out_instr,      32'd0);
        chk("t4 pc",     fu.out_pc,         32'h0000_0002);

        // Redirect coinciding with out_ready
        drive(0, 0, '0, 1, 32'h0000_1000, 1);   tick();
        chk("t5 count", fu.fetch_count,    32'd3);
        chk("t5 addr",  fu.ibus_addr,      32'h0000_1000);
        chk("t5 req",   32'(fu.ibus_req),  32'd1);
        chk("t5 valid", 32'(fu.out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rand_inputs(8);
            tick();
        end

        // Reset while a real fetch is outstanding
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            if (m_out && !m_stale) reached = 1'b1;
            else begin
                rand_inputs(2);
                tick();
            end
        end
        chk("t6 reached wait", 32'(reached), 32'd1);
        drive(0, 0, '0, 0, '0, 0);
        #2 reset = 1'b1;
        #1;
        chk("t6 rst req",   32'(fu.ibus_req),  32'd1);
        chk("t6 rst addr",  fu.ibus_addr,      32'hbfc0_0000);
        chk("t6 rst valid", 32'(fu.out_valid), 32'd0);
        chk("t6 rst count", fu.fetch_count,    32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        model_cmp();
        drive(1, 0, '0, 0, '0, 0);              tick();
        drive(0, 1, 32'h0000_0000, 0, '0, 0);   tick();
        chk("t6 out_pc", fu.out_pc, 32'hbfc0_0000);
        drive(0, 0, '0, 0, '0, 1);              tick();
        chk("t6 count", fu.fetch_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
